wave_mode_ctrl: RTL and testbench
=================================

# wave_mode_ctrl

Click-free wave-type controller for the oscillator datapath. It converts the player's mode-key presses into a wave-select value and stages each change as a pending request. The change is committed to the oscillator only at a phase-wrap boundary, so the waveform never switches mid-cycle. It sits between the key input conditioning and the oscillator/wave-shaper select input.

## Interface
Parameters:
- TIMEOUT_CYCLES, 4096: maximum cycles a request may stay pending before a forced commit; ≥2; applies only with the timeout feature compiled in.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- n_rst  in  1  reset; synchronous, active-low.
- mode_key  in  1  conditioned mode-key level; already synchronized and debounced upstream.
- dir  in  1  step direction, sampled on the press cycle: 0 = next wave, 1 = previous wave.
- phase_wrap  in  1  one-cycle strobe from the oscillator when its phase accumulator wraps.
- wave_sel  out  2  committed wave type (wave_t): 0 SQUARE, 1 SAW, 2 TRIANGLE, 3 SINE.
- pending  out  1  a change is staged and not yet committed.
- changed  out  1  one-cycle pulse in the cycle after wave_sel updates.

## Operation
- Press detect:
  - key_prev registers mode_key.
  - press = mode_key & ~key_prev.
  - key_prev resets to 1, so a key held through reset is not a press.
- target (2 bits):
  - On a press, target steps ±1 mod 4 according to dir: 3+1 → 0 and 0−1 → 3.
  - The step base is wave_sel in IDLE and target in PENDING.
- FSM states and transitions:
  - IDLE, on press: go to PENDING with target = wave_sel ± 1. A phase_wrap in the same cycle is ignored.
  - IDLE, on phase_wrap without press: no effect.
  - PENDING, on press: target steps. If the new target equals wave_sel (the net change cancels), go to IDLE with no commit and no changed pulse.
  - PENDING, on phase_wrap: commit wave_sel ← target, pulse changed, go to IDLE.
  - PENDING, press and phase_wrap in the same cycle: apply the press first, then commit the stepped target. If that target equals wave_sel, this is a cancel with no changed pulse.
- pending = (state == PENDING).
- All outputs are registered.
- Reset values:
  - state IDLE, wave_sel 0 (SQUARE), target 0.
  - pending 0, changed 0, timeout counter 0.
  - Reset asserted mid-pending discards the request.

## Timing
- mode_key rises and is sampled high at edge N → pending = 1 after edge N.
- phase_wrap sampled at edge M while pending:
  - wave_sel shows the new value and changed = 1 after edge M.
  - pending = 0 after edge M.
  - changed drops after edge M+1.
- Minimum spacing between two presses: 2 cycles (key must be low for one sampled cycle). Each press is counted exactly once.
- Back-to-back requests: a new press in the cycle right after a commit starts a new pending request normally.
- changed never asserts for two consecutive cycles.

## Configuration
- WAVE_MODE_TIMEOUT_EN defined: timeout for oscillators that stop wrapping (e.g. gated or zero frequency).
  - Counter width is $clog2(TIMEOUT_CYCLES).
  - The counter clears on entry to PENDING and increments each PENDING cycle. Extra presses do not restart it.
  - In a PENDING cycle where the counter equals TIMEOUT_CYCLES−1 and no phase_wrap is present, commit exactly as for phase_wrap.
  - A request entered at edge N therefore commits after edge N+TIMEOUT_CYCLES.
- Undefined: no counter logic. A request stays pending indefinitely until phase_wrap, a cancel, or reset.

## Structure
- Shared package synth_pkg holds:
  - typedef enum logic [1:0] wave_t {SQUARE, SAW, TRIANGLE, SINE};
  - the NUM_WAVES = 4 constant.
- The FSM state enum is local to the block.
- Sub-module key_edge_det: single-cycle rising-edge pulse generator with reset-high history. The keypad path reuses it.

## Test plan
- Reset, then one press with dir=0, then phase_wrap 5 cycles later → pending high after the press; wave_sel 0→1 one cycle after the wrap; changed high for exactly 1 cycle.
- Three presses, dir=0, then one wrap → single commit wave_sel 0→3 with one changed pulse. A further press with dir=0 and a wrap → 3→0 (wrap-around).
- Press dir=0 then press dir=1 before any wrap → pending returns to 0; a later wrap leaves wave_sel=0 and changed stays 0.
- Press and phase_wrap in the same cycle from IDLE → no commit; the next wrap commits 1. Press and wrap in the same cycle while pending at target 1 → commits 2.
- Key held high through reset release → no pending. Reset asserted while pending → wave_sel 0, pending 0, no changed pulse.
- With WAVE_MODE_TIMEOUT_EN and TIMEOUT_CYCLES=8: press, no wrap → commit after exactly 8 cycles. Without the macro: still pending after 10000 cycles.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared synthesizer types: wave selection encoding and a wrap-around wave stepper.
package synth_pkg;

  typedef enum logic [1:0] {SQUARE, SAW, TRIANGLE, SINE} wave_t;

  localparam int unsigned NUM_WAVES = 4;

  // dir = 0 steps to the next wave, dir = 1 to the previous one, wrapping mod NUM_WAVES.
  function automatic wave_t step_wave(input wave_t base, input logic dir);
    logic [31:0] sum;
    sum = 32'(base) + (dir ? NUM_WAVES - 32'd1 : 32'd1);
    return wave_t'(2'(sum % NUM_WAVES));
  endfunction

endpackage

// File: rtl/key_edge_det.sv
// Single-cycle rising-edge pulse generator; history resets high so a key held
// through reset does not register as a press.
module key_edge_det (
  input  logic clk,
  input  logic n_rst,
  input  logic level,
  output logic pulse
);

  logic prev_q;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= level;
    end
  end

  assign pulse = level & ~prev_q;

endmodule

// File: rtl/wave_mode_ctrl.sv
// Click-free wave-type controller: key presses stage a wave change that commits on phase wrap.
// Optional forced commit for stalled oscillators when WAVE_MODE_TIMEOUT_EN is defined.
module wave_mode_ctrl
  import synth_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       mode_key,
  input  logic       dir,
  input  logic       phase_wrap,
  output logic [1:0] wave_sel,
  output logic       pending,
  output logic       changed
);

  typedef enum logic {StIdle, StPending} state_e;

  state_e state_q, state_d;
  wave_t  wave_q, wave_d;
  wave_t  target_q, target_d;
  logic   changed_q, changed_d;
  logic   press;
  logic   timeout;
  wave_t  stepped;

  key_edge_det u_key_edge (
    .clk   (clk),
    .n_rst (n_rst),
    .level (mode_key),
    .pulse (press)
  );

`ifdef WAVE_MODE_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Held at zero while idle so it reads 0 in the first pending cycle.
  always_comb begin
    cnt_d = '0;
    if (state_q == StPending) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout = (state_q == StPending) && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    wave_d    = wave_q;
    target_d  = target_q;
    changed_d = 1'b0;
    stepped   = press ? step_wave(target_q, dir) : target_q;

    unique case (state_q)
      StIdle: begin
        if (press) begin
          target_d = step_wave(wave_q, dir);
          state_d  = StPending;
        end
      end
      StPending: begin
        target_d = stepped;
        // A press that walks the target back to the live wave cancels, even alongside a wrap.
        if (press && (stepped == wave_q)) begin
          state_d = StIdle;
        end else if (phase_wrap || timeout) begin
          wave_d    = stepped;
          changed_d = 1'b1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q   <= StIdle;
      wave_q    <= SQUARE;
      target_q  <= SQUARE;
      changed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wave_q    <= wave_d;
      target_q  <= target_d;
      changed_q <= changed_d;
    end
  end

  assign wave_sel = wave_q;
  assign pending  = (state_q == StPending);
  assign changed  = changed_q;

endmodule

// File: tb/tb_wave_mode_ctrl.sv
// Self-checking bench for wave_mode_ctrl: directed scenarios plus random stimulus
// against a cycle-level integer reference model.
module tb_wave_mode_ctrl;

  localparam int unsigned TO = 8;

  logic       clk;
  logic       n_rst;
  logic       mode_key;
  logic       dir;
  logic       phase_wrap;
  logic [1:0] wave_sel;
  logic       pending;
  logic       changed;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  int cyc     = 0;
  int m_wave  = 0;
  int m_tgt   = 0;
  int m_pend  = 0;
  int m_chg   = 0;
  int m_prev  = 1;
  int m_entry = 0;

  wave_mode_ctrl #(
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .mode_key   (mode_key),
    .dir        (dir),
    .phase_wrap (phase_wrap),
    .wave_sel   (wave_sel),
    .pending    (pending),
    .changed    (changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model(input logic rst, input logic key, input logic d, input logic wrap);
    int  step;
    bit  press;
    bit  fire;
    if (!rst) begin
      m_prev = 1; m_wave = 0; m_tgt = 0; m_pend = 0; m_chg = 0;
    end else begin
      press  = (key == 1'b1) && (m_prev == 0);
      m_prev = int'(key);
      step   = d ? 3 : 1;
      m_chg  = 0;
      if (m_pend == 0) begin
        if (press) begin
          m_tgt   = (m_wave + step) % 4;
          m_pend  = 1;
          m_entry = cyc;
        end
      end else begin
        if (press) m_tgt = (m_tgt + step) % 4;
        fire = wrap;
`ifdef WAVE_MODE_TIMEOUT_EN
        if (cyc - m_entry == int'(TO)) fire = 1'b1;
`endif
        if (press && m_tgt == m_wave) begin
          m_pend = 0;
        end else if (fire) begin
          m_wave = m_tgt;
          m_chg  = 1;
          m_pend = 0;
        end
      end
    end
  endtask

  task automatic cycle(input logic rst, input logic key, input logic d, input logic wrap);
    n_rst      = rst;
    mode_key   = key;
    dir        = d;
    phase_wrap = wrap;
    @(posedge clk);
    cyc++;
    model(rst, key, d, wrap);
    #1;
    chk("wave_sel", 32'(wave_sel), 32'(m_wave));
    chk("pending",  32'(pending),  32'(m_pend));
    chk("changed",  32'(changed),  32'(m_chg));
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // Press with direction d, then release.
  task automatic press_rel(input logic d);
    cycle(1'b1, 1'b1, d, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    n_rst = 1'b0; mode_key = 1'b0; dir = 1'b0; phase_wrap = 1'b0;

    // Reset state
    do_reset();
    chk("rst_wave", 32'(wave_sel), 32'd0);
    chk("rst_pend", 32'(pending), 32'd0);
    chk("rst_chg",  32'(changed), 32'd0);

    // Single press, wrap 5 cycles later
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    chk("t1_pend", 32'(pending), 32'd1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t1_hold", 32'(wave_sel), 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    chk("t1_wave", 32'(wave_sel), 32'd1);
    chk("t1_chg",  32'(changed), 32'd1);
    chk("t1_pend0", 32'(pending), 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t1_chg_drop", 32'(changed), 32'd0);

    // Three presses then a wrap: 0 -> 3; then one more: 3 -> 0
    do_reset();
    press_rel(1'b0); press_rel(1'b0); press_rel(1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    chk("t2_wave3", 32'(wave_sel), 32'd3);
    chk("t2_chg", 32'(changed), 32'd1);
    press_rel(1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    chk("t2_wrap0", 32'(wave_sel), 32'd0);

    // Net-zero presses cancel
    press_rel(1'b0);
    press_rel(1'b1);
    chk("t3_pend", 32'(pending), 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    chk("t3_wave", 32'(wave_sel), 32'd0);
    chk("t3_chg", 32'(changed), 32'd0);

    // Press with wrap from idle: wrap ignored, next wrap commits 1
    do_reset();
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    chk("t4_pend", 32'(pending), 32'd1);
    chk("t4_nocommit", 32'(wave_sel), 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    chk("t4_wave1", 32'(wave_sel), 32'd1);

    // Press with wrap while pending at target 1 commits 2
    do_reset();
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    chk("t4_wave2", 32'(wave_sel), 32'd2);
    chk("t4_chg2", 32'(changed), 32'd1);

    // Key held through reset release is not a press
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    chk("t5_held", 32'(pending), 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);

    // Reset while pending discards the request
    press_rel(1'b1);
    chk("t5_pend", 32'(pending), 32'd1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t5_rst_wave", 32'(wave_sel), 32'd0);
    chk("t5_rst_pend", 32'(pending), 32'd0);
    chk("t5_rst_chg", 32'(changed), 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);

    // Random stimulus against the model
    for (int i = 0; i < 800; i++) begin
      cycle(logic'($urandom_range(0, 79) != 0),
            logic'($urandom_range(0, 2) == 0),
            logic'($urandom_range(0, 1)),
            logic'($urandom_range(0, 5) == 0));
    end

    // Stalled oscillator: no wraps for a long time
    do_reset();
    press_rel(1'b0);
    for (int i = 0; i < 10000; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
`ifdef WAVE_MODE_TIMEOUT_EN
    chk("t6_timeout_wave", 32'(wave_sel), 32'd1);
`else
    chk("t6_still_pend", 32'(pending), 32'd1);
    chk("t6_still_wave", 32'(wave_sel), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
